// File: rtl/radixf_adder.sv
// rtl/radixf_adder.sv - registered M-digit hex adder with digit-serial carry chain
// Optional feature macro: RADIXF_DIGIT_CARRY_EN (adds registered per-digit carry-out port dcarry)
module radixf_adder #(
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [4*M-1:0] x,
    input  logic [4*M-1:0] y,
    input  logic           cin,
    output logic           out_valid,
    output logic [4*M-1:0] sum,
    output logic           cout
`ifdef RADIXF_DIGIT_CARRY_EN
    ,
    output logic [M-1:0]   dcarry
`endif
);

    logic [4*M-1:0] s_comb;
    logic           cout_comb;
`ifdef RADIXF_DIGIT_CARRY_EN
    logic [M-1:0]   dc_comb;
`endif

    // One 5-bit digit adder per hex digit; each digit's carry lives in its own
    // scope so the ripple is a chain of distinct nets rather than a self-feeding vector.
    for (genvar i = 0; i < M; i++) begin : g_digit
        logic       ci;
        logic       co;
        logic [4:0] d;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_rest
            assign ci = g_digit[i-1].co;
        end
        assign d                 = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0000, ci};
        assign s_comb[4*i +: 4]  = d[3:0];
        assign co                = d[4];
`ifdef RADIXF_DIGIT_CARRY_EN
        assign dc_comb[i]        = co;
`endif
    end

    assign cout_comb = g_digit[M-1].co;

    logic           out_valid_q, out_valid_d;
    logic [4*M-1:0] sum_q, sum_d;
    logic           cout_q, cout_d;
`ifdef RADIXF_DIGIT_CARRY_EN
    logic [M-1:0]   dcarry_q, dcarry_d;
`endif

    // Next-state: load a fresh result on in_valid, otherwise hold and drop valid.
    always_comb begin
        out_valid_d = in_valid;
        sum_d       = sum_q;
        cout_d      = cout_q;
`ifdef RADIXF_DIGIT_CARRY_EN
        dcarry_d    = dcarry_q;
`endif
        if (in_valid) begin
            sum_d    = s_comb;
            cout_d   = cout_comb;
`ifdef RADIXF_DIGIT_CARRY_EN
            dcarry_d = dc_comb;
`endif
        end
    end

    // Result registers; async reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef RADIXF_DIGIT_CARRY_EN
            dcarry_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
`ifdef RADIXF_DIGIT_CARRY_EN
            dcarry_q    <= dcarry_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef RADIXF_DIGIT_CARRY_EN
    assign dcarry    = dcarry_q;
`endif

endmodule

// File: tb/tb_radixf_adder.sv
// tb/tb_radixf_adder.sv - self-checking bench for radixf_adder against an arithmetic model
module tb_radixf_adder;
    localparam int M = 4;
    localparam int W = 4 * M;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
`ifdef RADIXF_DIGIT_CARRY_EN
    logic [M-1:0] dcarry;
`endif

    radixf_adder #(.M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
`ifdef RADIXF_DIGIT_CARRY_EN
        ,
        .dcarry    (dcarry)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic         exp_valid;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic [M-1:0] exp_dc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        check({tag, ".sum"},       64'(sum),       64'(exp_sum));
        check({tag, ".cout"},      64'(cout),      64'(exp_cout));
`ifdef RADIXF_DIGIT_CARRY_EN
        check({tag, ".dcarry"},    64'(dcarry),    64'(exp_dc));
`endif
    endtask

    // Reference: plain integer addition; digit carry i is overflow of the low (i+1) digits.
    task automatic model_apply(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic ci);
        longint full;
        longint modv;
        full     = longint'(xv) + longint'(yv) + longint'(ci);
        exp_sum  = W'(full % (longint'(1) << W));
        exp_cout = (full >= (longint'(1) << W));
        for (int i = 0; i < M; i++) begin
            modv      = longint'(1) << (4 * (i + 1));
            exp_dc[i] = ((longint'(xv) % modv) + (longint'(yv) % modv) + longint'(ci)) >= modv;
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_sum   = '0;
        exp_cout  = 1'b0;
        exp_dc    = '0;
    endtask

    task automatic drive(input string tag, input logic v, input logic [W-1:0] xv,
                         input logic [W-1:0] yv, input logic ci);
        @(negedge clk);
        in_valid = v;
        x        = xv;
        y        = yv;
        cin      = ci;
        @(posedge clk);
        exp_valid = v;
        if (v) model_apply(xv, yv, ci);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] hold_sum;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        cin      = 1'b0;
        model_reset();
        #7;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive("t1_basic",     1'b1, 16'h121a, 16'h211b, 1'b0);
        drive("t2_ripple",    1'b1, 16'hFFFF, 16'h0001, 1'b0);
        drive("t3_maxcin",    1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        drive("t4_digit0",    1'b1, 16'h000F, 16'h0001, 1'b0);

        drive("t5_load",      1'b1, 16'h89AB, 16'h7777, 1'b1);
        hold_sum = exp_sum;
        for (int i = 0; i < 3; i++) begin
            drive("t5_hold", 1'b0, W'($urandom), W'($urandom), 1'($urandom));
        end
        check("t5_hold_sum_unchanged", 64'(sum), 64'(hold_sum));

        // Async reset pulse between edges while in_valid is high.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 16'h1234;
        y        = 16'h4321;
        cin      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async_rst");
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("t6_after_rst");

        drive("t6_first_cap", 1'b1, 16'h0F0F, 16'h0101, 1'b1);

        for (int i = 0; i < 40; i++) begin
            drive("rand", 1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1);
    end
endmodule
